fsu_bit_decoder: RTL and testbench
==================================

# fsu_bit_decoder

Windowed bitstream decoder that converts one stochastic (unary) bitstream, such as the scaled-sum output of the FSU adder, back into a binary value. It counts the ones over a fixed window of 2^IWID valid bits and emits the count, unipolar or bipolar, with a one-cycle valid pulse. It sits at the boundary between the unary datapath and binary consumers: result capture, accuracy checking and the binary-domain layers of uBrain.

## Interface
Parameters:
- IWID, 8, log2 of window length; window N = 2^IWID valid bits; output width IWID+1.
- BIPO, 0, 0 = unipolar (oData = ones, unsigned), 1 = bipolar (oData = ones − 2^(IWID−1), two's complement).
- CONT, 0, 0 = single-shot window per iStart; 1 = windows repeat back-to-back until reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- iStart  input  1  begin a window; honoured only in IDLE.
- iBit  input  1  stream bit.
- iBitValid  input  1  iBit is sampled only when high; low = stall.
- oBusy  output  1  high while in RUN.
- oData  output  IWID+1  decoded result; holds until next oValid.
- oValid  output  1  one-cycle pulse; oData updated in the same cycle.

## Operation
- State machine has two states, IDLE and RUN. Reset enters IDLE with ones=0, win=0, oData=0, oValid=0, oBusy=0.
- In IDLE, iStart=1 moves the block to RUN next cycle and clears ones and win. iBit is not sampled in the iStart cycle.
- In RUN, each cycle with iBitValid=1 does ones += iBit and win += 1. iBitValid=0 holds both.
- Final bit: the cycle in RUN with iBitValid=1 and win == N−1.
  - That cycle registers total = ones + iBit into oData (mapped per BIPO) and sets oValid=1 for the next cycle.
  - It clears ones and win.
  - With CONT=0, the next state is IDLE. With CONT=1, the block stays in RUN and samples the next window from the following cycle, with no gap.
- Widths:
  - ones is IWID+1 bits, range 0..N, and never wraps.
  - win is IWID bits and wraps only at the final bit.
  - Bipolar mapping is total − 2^(IWID−1), giving a range of −N/2..+N/2 in IWID+1 signed bits.
- iStart while in RUN is ignored. It does not restart the window.
- With CONT=0, iStart may be high in the cycle oValid pulses, because the state is already IDLE. The block then enters RUN on the next cycle.
- rst at any time, including mid-window, aborts the window. No oValid is produced for it, and all outputs return to reset values next cycle.
- oValid is never high for two consecutive cycles unless CONT=1 and IWID=0. IWID ≥ 1 is required.

## Timing
- iStart sampled at edge t: oBusy=1 from t+1. Valid bits are sampled at edges t+1 onward.
- With no stalls, the final bit is sampled at edge t+N. oValid=1 and the new oData are visible in cycle t+N+1.
- With CONT=0, oBusy=0 in cycle t+N+1. With CONT=1, oBusy stays 1.
- Each stall cycle adds exactly one cycle of latency.
- With CONT=1 there is one oValid every N valid bits. Throughput is 1 result per N valid cycles.
- oData changes only on the cycle oValid rises, or on reset.

## Test plan
IWID=4 (N=16) unless noted.
- All-ones, BIPO=0: iStart at cycle 0, iBit=1 for 16 valid cycles -> oValid single pulse at cycle 17, oData=16. With BIPO=1 -> oData=+8.
- All-zeros and alternating 1/0 (BIPO=1) -> oData=−8 (0x18 in 5 bits) and 0. With BIPO=0 -> 0 and 8.
- Random iBitValid stalls (40% low), 10 ones among 16 valid bits, BIPO=0 -> oData=10. oValid arrives exactly 1 cycle after the 16th valid bit. Stalled iBit values are ignored.
- CONT=1, three windows with 3, 16 and 0 ones -> oValid pulses exactly 16 cycles apart, oData=3, 16, 0, and oBusy stays high throughout.
- iStart pulsed mid-window, then rst asserted after 9 valid bits -> window not restarted by iStart. After rst: oValid=0, oData=0, oBusy=0. A new iStart yields a correct result counting only new bits.
- CONT=0: iStart held high through the oValid cycle -> new window starts in the next cycle, and its result is correct 17 cycles after the first oValid.

Source files
------------

// File: rtl/fsu_bit_decoder_if.sv
// Handshake bundle between a unary bitstream source and the windowed bit decoder.
interface fsu_bit_decoder_if #(
  parameter int IWID = 8
);
  logic          iStart;
  logic          iBit;
  logic          iBitValid;
  logic          oBusy;
  logic [IWID:0] oData;
  logic          oValid;

  modport master (
    output iStart, iBit, iBitValid,
    input  oBusy, oData, oValid
  );

  modport slave (
    input  iStart, iBit, iBitValid,
    output oBusy, oData, oValid
  );
endinterface

// File: rtl/fsu_bit_decoder.sv
// Counts ones over a window of 2^IWID valid stream bits and emits the count,
// unipolar or bipolar, with a one-cycle valid pulse.
module fsu_bit_decoder #(
  parameter int IWID = 8,
  parameter bit BIPO = 1'b0,
  parameter bit CONT = 1'b0
) (
  input logic              clk,
  input logic              rst,
  fsu_bit_decoder_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IWID-1:0] WIN_LAST = {IWID{1'b1}};
  localparam logic [IWID:0]   HALF     = (IWID+1)'(1) << (IWID - 1);

  state_t        state;
  logic [IWID:0]   ones;
  logic [IWID-1:0] win;
  logic [IWID:0]   total;
  logic [IWID:0]   mapped;

  // Final-bit total includes the bit being sampled this cycle.
  always_comb begin
    total  = ones + {{IWID{1'b0}}, bus.iBit};
    mapped = total;
    if (BIPO) mapped = total - HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ones       <= '0;
      win        <= '0;
      bus.oData  <= '0;
      bus.oValid <= 1'b0;
      bus.oBusy  <= 1'b0;
    end else begin
      bus.oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            state     <= RUN;
            ones      <= '0;
            win       <= '0;
            bus.oBusy <= 1'b1;
          end
        end
        RUN: begin
          if (bus.iBitValid) begin
            if (win == WIN_LAST) begin
              bus.oData  <= mapped;
              bus.oValid <= 1'b1;
              ones       <= '0;
              win        <= '0;
              // Continuous mode rolls straight into the next window.
              if (!CONT) begin
                state     <= IDLE;
                bus.oBusy <= 1'b0;
              end
            end else begin
              ones <= total;
              win  <= win + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bus.oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsu_bit_decoder.sv
// Directed bench for fsu_bit_decoder: unipolar, bipolar and continuous instances at IWID=4.
module tb_fsu_bit_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fsu_bit_decoder_if #(.IWID(4)) ifU ();
  fsu_bit_decoder_if #(.IWID(4)) ifB ();
  fsu_bit_decoder_if #(.IWID(4)) ifC ();

  fsu_bit_decoder #(.IWID(4), .BIPO(1'b0), .CONT(1'b0)) dutU (.clk(clk), .rst(rst), .bus(ifU));
  fsu_bit_decoder #(.IWID(4), .BIPO(1'b1), .CONT(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  fsu_bit_decoder #(.IWID(4), .BIPO(1'b0), .CONT(1'b1)) dutC (.clk(clk), .rst(rst), .bus(ifC));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic start, input logic bitIn, input logic valid);
    ifU.iStart = start; ifU.iBit = bitIn; ifU.iBitValid = valid;
    ifB.iStart = start; ifB.iBit = bitIn; ifB.iBitValid = valid;
  endtask

  // One window on the unipolar and bipolar instances; stall cycles drive iBit=1 as garbage.
  task automatic applyStimulus(input string name, input logic [15:0] pattern,
                               input logic [31:0] stallMask, input int startAt,
                               input int expCycles, input logic [4:0] expU, input logic [4:0] expB);
    int cyc = 0;
    int k = 0;
    int early = 0;
    setIn(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput({name, "_busy"}, {31'd0, ifU.oBusy}, 32'd1);
    while (k < 16 && cyc < 100) begin
      if (stallMask[cyc % 32]) setIn(cyc == startAt, 1'b1, 1'b0);
      else                     setIn(cyc == startAt, pattern[k], 1'b1);
      tick();
      if (!stallMask[cyc % 32]) k++;
      cyc++;
      if (k < 16 && (ifU.oValid || ifB.oValid)) early++;
    end
    checkOutput({name, "_done"}, k, 16);
    checkOutput({name, "_cycles"}, cyc, expCycles);
    checkOutput({name, "_early"}, early, 0);
    checkOutput({name, "_validU"}, {31'd0, ifU.oValid}, 32'd1);
    checkOutput({name, "_validB"}, {31'd0, ifB.oValid}, 32'd1);
    checkOutput({name, "_dataU"}, {27'd0, ifU.oData}, {27'd0, expU});
    checkOutput({name, "_dataB"}, {27'd0, ifB.oData}, {27'd0, expB});
    checkOutput({name, "_idle"}, {31'd0, ifU.oBusy}, 32'd0);
    setIn(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput({name, "_pulse"}, {31'd0, ifU.oValid}, 32'd0);
    checkOutput({name, "_hold"}, {27'd0, ifU.oData}, {27'd0, expU});
  endtask

  initial begin
    logic [15:0] contPat [3];
    logic [4:0]  contExp [3];
    int pulses;
    int lastPulse;
    int busyDrops;
    int cycs;

    setIn(1'b0, 1'b0, 1'b0);
    ifC.iStart = 1'b0; ifC.iBit = 1'b0; ifC.iBitValid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_validU", {31'd0, ifU.oValid}, 32'd0);
    checkOutput("reset_dataU", {27'd0, ifU.oData}, 32'd0);
    checkOutput("reset_busyU", {31'd0, ifU.oBusy}, 32'd0);
    checkOutput("reset_busyC", {31'd0, ifC.oBusy}, 32'd0);

    applyStimulus("ones",  16'hFFFF, 32'h0, -1, 16, 5'd16, 5'h08);
    applyStimulus("zeros", 16'h0000, 32'h0, -1, 16, 5'd0,  5'h18);
    applyStimulus("alt",   16'h5555, 32'h0,  5, 16, 5'd8,  5'h00);
    applyStimulus("stall", 16'b1011_0110_1101_1010, 32'h012526A6, -1, 27, 5'd10, 5'h02);

    // Abort mid-window with reset after a spurious iStart.
    setIn(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      setIn(i == 4, 1'b1, 1'b1);
      tick();
    end
    checkOutput("abort_busy", {31'd0, ifU.oBusy}, 32'd1);
    rst = 1'b1;
    setIn(1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    checkOutput("abort_valid", {31'd0, ifU.oValid}, 32'd0);
    checkOutput("abort_data", {27'd0, ifU.oData}, 32'd0);
    checkOutput("abort_busyU", {31'd0, ifU.oBusy}, 32'd0);
    applyStimulus("after", 16'h000F, 32'h0, -1, 16, 5'd4, 5'h1C);

    // Single-shot with iStart held across the result cycle.
    setIn(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      setIn(1'b1, i < 8, 1'b1);
      tick();
    end
    checkOutput("held_valid1", {31'd0, ifU.oValid}, 32'd1);
    checkOutput("held_data1", {27'd0, ifU.oData}, 32'd8);
    setIn(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("held_busy", {31'd0, ifU.oBusy}, 32'd1);
    cycs = 1;
    for (int i = 0; i < 16; i++) begin
      setIn(1'b0, i < 2, 1'b1);
      tick();
      cycs++;
      if (i < 15 && ifU.oValid) checkOutput("held_early", 32'd1, 32'd0);
    end
    checkOutput("held_gap", cycs, 17);
    checkOutput("held_valid2", {31'd0, ifU.oValid}, 32'd1);
    checkOutput("held_data2U", {27'd0, ifU.oData}, 32'd2);
    checkOutput("held_data2B", {27'd0, ifB.oData}, 32'h1A);
    setIn(1'b0, 1'b0, 1'b0);

    // Continuous mode: three back-to-back windows.
    contPat[0] = 16'h0007; contExp[0] = 5'd3;
    contPat[1] = 16'hFFFF; contExp[1] = 5'd16;
    contPat[2] = 16'h0000; contExp[2] = 5'd0;
    ifC.iStart = 1'b1;
    tick();
    ifC.iStart = 1'b0;
    pulses = 0; lastPulse = -1; busyDrops = 0;
    for (int c = 0; c < 48; c++) begin
      ifC.iBit = contPat[c / 16][c % 16];
      ifC.iBitValid = 1'b1;
      tick();
      if (!ifC.oBusy) busyDrops++;
      if (ifC.oValid) begin
        checkOutput("cont_at", c, pulses * 16 + 15);
        if (pulses < 3) checkOutput("cont_data", {27'd0, ifC.oData}, {27'd0, contExp[pulses]});
        if (lastPulse >= 0) checkOutput("cont_gap", c - lastPulse, 16);
        lastPulse = c;
        pulses++;
      end
    end
    checkOutput("cont_pulses", pulses, 3);
    checkOutput("cont_busy", busyDrops, 0);
    ifC.iBitValid = 1'b0;
    tick();
    checkOutput("cont_stillbusy", {31'd0, ifC.oBusy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
